uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, 4, number of requesters; fixed at 4, giving a 2-bit requester ID.
REQ-002 Parameter GAP_CYCLES, 16, idle clk_T cycles enforced between consecutive frames.
REQ-003 Parameter LAUNCH_TIMEOUT, 1024, clk_T cycles to wait for tx_busy after asserting tx_send.
REQ-004 clk_T  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 req  input  4  per-requester level request; req[i] held high while data[i] is valid.
REQ-007 data  input  32  requester bytes; data[8i+7:8i] belongs to requester i.
REQ-008 req_ack  output  4  one-cycle pulse; bit i high means requester i's byte was captured.
REQ-009 tx_send  output  1  send strobe to the UART transmitter.
REQ-010 tx_data  output  8  byte presented to the UART transmitter.
REQ-011 tx_busy  input  1  UART transmitter busy flag.
REQ-012 active_id  output  2  ID of the requester currently owning the transmitter.
REQ-013 ctrl_busy  output  1  high in every state except IDLE.
REQ-014 clear_err  input  1  synchronous clear of timeout_err.
REQ-015 timeout_err  output  1  sticky flag: a launch timed out.
REQ-016 frame_count  output  16  count of frames successfully handed to the UART; wraps.

Function
REQ-017 The FSM SHALL have four states: IDLE, LAUNCH, WAIT_DONE and GAP, encoded in 2 bits.
REQ-018 IDLE: if any req bit is high at a clock edge, the block SHALL grant the first requester at or after last_grant+1 (mod 4). In that same edge it SHALL latch the granted byte into tx_data, set active_id, pulse req_ack for one cycle, update last_grant and enter LAUNCH.
REQ-019 Round-robin fairness: when all four requests are held continuously, grants SHALL rotate 0,1,2,3,0, with no requester granted twice while another is pending.
REQ-020 A req bit dropped before it is sampled in IDLE SHALL NOT be granted; req is ignored in every state other than IDLE.
REQ-021 LAUNCH: tx_send SHALL be high in every LAUNCH cycle, and tx_data SHALL be stable.
REQ-022 LAUNCH exit on tx_busy=1: the block SHALL enter WAIT_DONE and increment frame_count by 1 (16-bit, FFFF wraps to 0000).
REQ-023 LAUNCH exit on timeout: if tx_busy stays 0 for LAUNCH_TIMEOUT consecutive LAUNCH cycles, the block SHALL set timeout_err, drop the byte, leave frame_count unchanged and return to IDLE.
REQ-024 WAIT_DONE: tx_send SHALL be 0; the block SHALL enter GAP on the first cycle tx_busy is sampled 0.
REQ-025 GAP: tx_send SHALL be 0; the block SHALL stay in GAP for exactly GAP_CYCLES cycles, then enter IDLE.
REQ-026 The first IDLE arbitration after a frame SHALL occur no earlier than GAP_CYCLES+1 cycles after tx_busy falls.
REQ-027 When clear_err and a timeout occur in the same cycle, timeout_err SHALL be set (set wins).
REQ-028 req_ack SHALL be one-hot or zero in every cycle.
REQ-029 tx_data and active_id SHALL hold their last values outside LAUNCH.

Reset
REQ-030 While reset=0, the block SHALL asynchronously force: state IDLE, tx_send 0, tx_data 00, req_ack 0000, active_id 0, ctrl_busy 0, timeout_err 0, frame_count 0000, last_grant 3.
REQ-031 Reset asserted mid-frame (LAUNCH, WAIT_DONE or GAP) SHALL abort the frame immediately. After reset release, the first grant SHALL go to the lowest-numbered requester whose req is high.
REQ-032 The first clock edge after reset deasserts SHALL perform normal IDLE arbitration.

Verification
REQ-033 Single request: req=0001, data[7:0]=18, BFM raises busy 3 cycles after send and holds it 40 cycles -> req_ack=0001 for one cycle, tx_data=18, tx_send high 3 cycles, frame_count=1, ctrl_busy low 16 cycles after busy falls.
REQ-034 All four requesters with bytes 55/AA/FF/0F on requesters 0-3, req held until ack -> tx_data sequence 55,AA,FF,0F; ack order 0001,0010,0100,1000; frame_count=4.
REQ-035 Timeout: req=0100, data=25, tx_busy tied 0 -> tx_send high exactly 1024 cycles, timeout_err=1, frame_count unchanged; clear_err pulse -> timeout_err=0.
REQ-036 Reset mid-frame: grant requester 2 (data=51), assert reset during WAIT_DONE with req=1010 -> outputs at reset values immediately; after release, requester 1 is granted first.
REQ-037 Late request: req[3] raised during GAP with data=96 -> no ack until IDLE, then ack=1000 and tx_data=96.
REQ-038 Wrap: preload via 65535 BFM frames, then one more frame -> frame_count=0000.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that hands one byte at a time from
// four requesters to a single UART transmitter, with a launch timeout and
// an enforced idle gap between frames.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no frame in flight; arbitrate among req on every edge
// LAUNCH    | tx_send held high until the UART reports busy or timer expires
// WAIT_DONE | UART is shifting the byte out; wait for tx_busy to drop
// GAP       | enforced idle spacing before the next arbitration
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int LAUNCH_TIMEOUT = 1024
) (
  input  logic                 clk_T,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   data,
  output logic [N_REQ-1:0]     req_ack,
  output logic                 tx_send,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [1:0]           active_id,
  output logic                 ctrl_busy,
  input  logic                 clear_err,
  output logic                 timeout_err,
  output logic [15:0]          frame_count
);

  // One down-counter serves both the launch timeout and the gap length,
  // since the two never run at the same time.
  localparam int TMAX = (LAUNCH_TIMEOUT > GAP_CYCLES) ? LAUNCH_TIMEOUT : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q;
  logic [1:0]      last_grant;
  logic [1:0]      grant_id;
  logic [1:0]      cand;
  logic            grant_valid;
  logic            grant_take;
  logic            frame_done;
  logic            timeout_hit;

  // Round-robin pick: scan from last_grant+1 upward; the loop runs from the
  // farthest candidate down so the nearest requesting one wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = last_grant;
    cand        = last_grant;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = last_grant + 2'(k);
      if (req[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
  end

  assign grant_take = (state_q == IDLE) && grant_valid;

  // State register.
  always_ff @(posedge clk_T or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_d     = state_q;
    tx_send     = 1'b0;
    ctrl_busy   = 1'b1;
    frame_done  = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        ctrl_busy = 1'b0;
        if (grant_valid) state_d = LAUNCH;
      end
      LAUNCH: begin
        tx_send = 1'b1;
        if (tx_busy) begin
          state_d    = WAIT_DONE;
          frame_done = 1'b1;
        end else if (timer_q == '0) begin
          state_d     = IDLE;
          timeout_hit = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = GAP;
      end
      GAP: begin
        if (timer_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shared down-counter: loaded on entry to LAUNCH or GAP, counts to zero.
  always_ff @(posedge clk_T or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
    end else if (grant_take) begin
      timer_q <= TW'(LAUNCH_TIMEOUT - 1);
    end else if (state_q == WAIT_DONE && !tx_busy) begin
      timer_q <= TW'(GAP_CYCLES - 1);
    end else if ((state_q == LAUNCH || state_q == GAP) && timer_q != '0) begin
      timer_q <= timer_q - TW'(1);
    end
  end

  // Grant capture: byte, owner and ack pulse are latched on the arbitration edge.
  always_ff @(posedge clk_T or negedge reset) begin
    if (!reset) begin
      tx_data    <= 8'h00;
      active_id  <= 2'd0;
      req_ack    <= '0;
      last_grant <= 2'd3;
    end else begin
      req_ack <= '0;
      if (grant_take) begin
        tx_data    <= data[8*grant_id +: 8];
        active_id  <= grant_id;
        last_grant <= grant_id;
        req_ack    <= N_REQ'(1) << grant_id;
      end
    end
  end

  // Status: sticky timeout flag (a new timeout beats a clear) and frame counter.
  always_ff @(posedge clk_T or negedge reset) begin
    if (!reset) begin
      timeout_err <= 1'b0;
      frame_count <= 16'h0000;
    end else begin
      if (timeout_hit)    timeout_err <= 1'b1;
      else if (clear_err) timeout_err <= 1'b0;
      if (frame_done)     frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_uart_tx_arbiter;

  logic        clk_T = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  req_ack;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  active_id;
  logic        ctrl_busy;
  logic        clear_err;
  logic        timeout_err;
  logic [15:0] frame_count;

  int tests = 0;
  int fails = 0;

  uart_tx_arbiter #(
    .N_REQ(4),
    .GAP_CYCLES(16),
    .LAUNCH_TIMEOUT(1024)
  ) dut (
    .clk_T(clk_T),
    .reset(reset),
    .req(req),
    .data(data),
    .req_ack(req_ack),
    .tx_send(tx_send),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .active_id(active_id),
    .ctrl_busy(ctrl_busy),
    .clear_err(clear_err),
    .timeout_err(timeout_err),
    .frame_count(frame_count)
  );

  always #5 clk_T = ~clk_T;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (req_ack == 4'b0000 && n < 200) begin
      @(negedge clk_T);
      n++;
    end
    chk("ack_within_bound", 32'(n < 200), 32'd1);
  endtask

  // Waits for the grant, checks it, drops that req bit, then models the UART:
  // busy rises 'dly' send-cycles after the grant and stays high for 'hold' cycles.
  task automatic do_frame(input logic [3:0] exp_ack, input logic [7:0] exp_data,
                          input int dly, input int hold);
    int n;
    wait_ack(n);
    chk("frame_ack", 32'(req_ack), 32'(exp_ack));
    chk("frame_data", 32'(tx_data), 32'(exp_data));
    chk("frame_send", 32'(tx_send), 32'd1);
    req = req & ~exp_ack;
    repeat (dly - 1) @(negedge clk_T);
    tx_busy = 1'b1;
    repeat (hold) @(negedge clk_T);
    tx_busy = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b0; req = 4'b0000; data = 32'h0; tx_busy = 1'b0; clear_err = 1'b0;

    // Reset values, before any clock edge.
    #2;
    chk("rst_tx_send", 32'(tx_send), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_req_ack", 32'(req_ack), 32'h0);
    chk("rst_active_id", 32'(active_id), 32'd0);
    chk("rst_ctrl_busy", 32'(ctrl_busy), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'h0);
    @(negedge clk_T);
    reset = 1'b1;

    // Single request, busy after 3 send cycles, held 40 cycles.
    data[7:0] = 8'h18;
    req = 4'b0001;
    @(negedge clk_T);
    chk("t1_ack", 32'(req_ack), 32'h1);
    chk("t1_data", 32'(tx_data), 32'h18);
    chk("t1_id", 32'(active_id), 32'd0);
    chk("t1_send_c1", 32'(tx_send), 32'd1);
    chk("t1_busy_c1", 32'(ctrl_busy), 32'd1);
    req = 4'b0000;
    @(negedge clk_T);
    chk("t1_send_c2", 32'(tx_send), 32'd1);
    chk("t1_ack_pulse", 32'(req_ack), 32'h0);
    @(negedge clk_T);
    chk("t1_send_c3", 32'(tx_send), 32'd1);
    tx_busy = 1'b1;
    @(negedge clk_T);
    chk("t1_send_off", 32'(tx_send), 32'd0);
    chk("t1_frames", 32'(frame_count), 32'd1);
    repeat (39) @(negedge clk_T);
    tx_busy = 1'b0;
    n = 0;
    repeat (17) begin
      @(negedge clk_T);
      if (ctrl_busy) n++;
    end
    chk("t1_gap_len", 32'(n), 32'd16);
    chk("t1_idle", 32'(ctrl_busy), 32'd0);
    chk("t1_data_hold", 32'(tx_data), 32'h18);

    // Four requesters held until acked: rotation 0,1,2,3 from a fresh reset.
    reset = 1'b0;
    @(negedge clk_T);
    reset = 1'b1;
    data = 32'h0FFF_AA55;
    req = 4'b1111;
    do_frame(4'b0001, 8'h55, 3, 5);
    do_frame(4'b0010, 8'hAA, 2, 4);
    do_frame(4'b0100, 8'hFF, 1, 3);
    do_frame(4'b1000, 8'h0F, 3, 6);
    chk("t2_frames", 32'(frame_count), 32'd4);

    // Launch timeout with tx_busy held low.
    data = 32'h0025_0000;
    req = 4'b0100;
    wait_ack(n);
    chk("t3_ack", 32'(req_ack), 32'h4);
    chk("t3_data", 32'(tx_data), 32'h25);
    req = 4'b0000;
    n = 0;
    while (tx_send && n < 2000) begin
      n++;
      @(negedge clk_T);
    end
    chk("t3_send_len", 32'(n), 32'd1024);
    chk("t3_err_set", 32'(timeout_err), 32'd1);
    chk("t3_frames_kept", 32'(frame_count), 32'd4);
    chk("t3_idle", 32'(ctrl_busy), 32'd0);
    @(negedge clk_T);
    chk("t3_err_sticky", 32'(timeout_err), 32'd1);
    clear_err = 1'b1;
    @(negedge clk_T);
    clear_err = 1'b0;
    chk("t3_err_clear", 32'(timeout_err), 32'd0);

    // Timeout coinciding with clear_err: the set wins.
    req = 4'b0100;
    wait_ack(n);
    req = 4'b0000;
    clear_err = 1'b1;
    n = 0;
    while (tx_send && n < 2000) begin
      n++;
      @(negedge clk_T);
    end
    clear_err = 1'b0;
    chk("t3b_send_len", 32'(n), 32'd1024);
    chk("t3b_set_wins", 32'(timeout_err), 32'd1);
    clear_err = 1'b1;
    @(negedge clk_T);
    clear_err = 1'b0;

    // Reset during WAIT_DONE, then first grant goes to the lowest requester.
    data = 32'h0051_0000;
    req = 4'b0100;
    wait_ack(n);
    chk("t4_ack", 32'(req_ack), 32'h4);
    chk("t4_data", 32'(tx_data), 32'h51);
    chk("t4_id", 32'(active_id), 32'd2);
    req = 4'b0000;
    tx_busy = 1'b1;
    @(negedge clk_T);
    @(negedge clk_T);
    chk("t4_in_frame", 32'(ctrl_busy), 32'd1);
    chk("t4_frames", 32'(frame_count), 32'd5);
    data = 32'h0000_3C00;
    req = 4'b1010;
    #1 reset = 1'b0;
    #1;
    chk("t4_rst_send", 32'(tx_send), 32'd0);
    chk("t4_rst_data", 32'(tx_data), 32'h00);
    chk("t4_rst_ack", 32'(req_ack), 32'h0);
    chk("t4_rst_id", 32'(active_id), 32'd0);
    chk("t4_rst_busy", 32'(ctrl_busy), 32'd0);
    chk("t4_rst_frames", 32'(frame_count), 32'h0);
    tx_busy = 1'b0;
    @(negedge clk_T);
    reset = 1'b1;
    wait_ack(n);
    chk("t4_first_edge", 32'(n), 32'd1);
    chk("t4_post_ack", 32'(req_ack), 32'h2);
    chk("t4_post_data", 32'(tx_data), 32'h3C);
    chk("t4_post_id", 32'(active_id), 32'd1);
    req = 4'b0000;
    @(negedge clk_T);
    tx_busy = 1'b1;
    repeat (3) @(negedge clk_T);
    tx_busy = 1'b0;

    // Request raised during GAP waits for IDLE: busy fell 18 negedges before the ack.
    repeat (3) @(negedge clk_T);
    chk("t5_in_gap", 32'(ctrl_busy), 32'd1);
    data = 32'h9600_0000;
    req = 4'b1000;
    n = 3;
    while (req_ack == 4'b0000 && n < 100) begin
      @(negedge clk_T);
      n++;
    end
    chk("t5_latency", 32'(n), 32'd18);
    chk("t5_ack", 32'(req_ack), 32'h8);
    chk("t5_data", 32'(tx_data), 32'h96);
    chk("t5_id", 32'(active_id), 32'd3);
    req = 4'b0000;
    @(negedge clk_T);
    tx_busy = 1'b1;
    @(negedge clk_T);
    chk("t5_frames", 32'(frame_count), 32'd2);
    tx_busy = 1'b0;
    repeat (20) @(negedge clk_T);
    chk("t5_idle", 32'(ctrl_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
